// File: rtl/fft_defs_pkg.sv
// Shared definitions for the FFT frame sequencer: bank and engine-tracker
// state encodings plus the BRAM address width used by the datapath engines.
package fft_defs;

    localparam int unsigned ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FULL     = 2'd1,
        B_COMPUTED = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_GO   = 2'd1,
        E_WAIT = 2'd2,
        E_RUN  = 2'd3
    } eng_state_t;

endpackage

// File: rtl/fft_engine_tracker.sv
// Per-engine handshake tracker: one-cycle go pulse, wait for busy to rise,
// then report completion on the cycle busy is seen low again.
module fft_engine_tracker
    import fft_defs::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic launch,
    input  logic busy,
    output logic go,
    output logic done
);

    eng_state_t r_state;
    eng_state_t w_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= E_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        go     = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            E_IDLE: if (launch) w_next = E_GO;
            E_GO: begin
                go     = 1'b1;
                w_next = E_WAIT;
            end
            E_WAIT: if (busy) w_next = E_RUN;
            E_RUN: begin
                if (!busy) begin
                    done   = 1'b1;
                    w_next = E_IDLE;
                end
            end
            default: w_next = E_IDLE;
        endcase
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame sequencer: owns bank states, per-engine bank pointers and
// the drained-frame counter; launches stream-in, FFT and stream-out engines.
module fft_frame_sequencer
    import fft_defs::*;
#(
    parameter int unsigned FRAME_CNT_WIDTH = 16,
    parameter int unsigned NUM_BANKS       = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    output logic                       slave_go,
    output logic                       fft_go,
    output logic                       master_go,
    input  logic                       slave_busy,
    input  logic                       fft_busy,
    input  logic                       master_busy,
    output logic                       wr_bank,
    output logic                       fft_bank,
    output logic                       rd_bank,
    output logic [FRAME_CNT_WIDTH-1:0] frames_done,
    output logic                       seq_idle
);

    localparam int unsigned PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    bank_state_t                r_bank [NUM_BANKS];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_fft_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [FRAME_CNT_WIDTH-1:0] r_frames;
    logic [NUM_BANKS-1:0]       r_filling;
    logic [NUM_BANKS-1:0]       r_computing;
    logic [NUM_BANKS-1:0]       r_draining;

    logic w_slave_launch, w_fft_launch, w_master_launch;
    logic w_slave_done, w_fft_done, w_master_done;
    logic w_all_empty;
    logic w_any_active;

    assign w_slave_launch  = enable && (r_bank[r_wr_ptr] == B_EMPTY);
    assign w_fft_launch    = (r_bank[r_fft_ptr] == B_FULL);
    assign w_master_launch = (r_bank[r_rd_ptr] == B_COMPUTED);

    fft_engine_tracker u_slave_trk (
        .clk     (clk),
        .reset_n (reset_n),
        .launch  (w_slave_launch),
        .busy    (slave_busy),
        .go      (slave_go),
        .done    (w_slave_done)
    );

    fft_engine_tracker u_fft_trk (
        .clk     (clk),
        .reset_n (reset_n),
        .launch  (w_fft_launch),
        .busy    (fft_busy),
        .go      (fft_go),
        .done    (w_fft_done)
    );

    fft_engine_tracker u_master_trk (
        .clk     (clk),
        .reset_n (reset_n),
        .launch  (w_master_launch),
        .busy    (master_busy),
        .go      (master_go),
        .done    (w_master_done)
    );

    // Ownership is disjoint, so all three completions may land in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                r_bank[i] <= B_EMPTY;
            end
            r_wr_ptr    <= '0;
            r_fft_ptr   <= '0;
            r_rd_ptr    <= '0;
            r_frames    <= '0;
            r_filling   <= '0;
            r_computing <= '0;
            r_draining  <= '0;
        end else begin
            if (slave_go) begin
                r_filling[r_wr_ptr] <= 1'b1;
            end
            if (w_slave_done) begin
                r_filling[r_wr_ptr] <= 1'b0;
                r_bank[r_wr_ptr]    <= B_FULL;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (fft_go) begin
                r_computing[r_fft_ptr] <= 1'b1;
            end
            if (w_fft_done) begin
                r_computing[r_fft_ptr] <= 1'b0;
                r_bank[r_fft_ptr]      <= B_COMPUTED;
                r_fft_ptr              <= r_fft_ptr + 1'b1;
            end
            if (master_go) begin
                r_draining[r_rd_ptr] <= 1'b1;
                r_bank[r_rd_ptr]     <= B_DRAINING;
            end
            if (w_master_done) begin
                r_draining[r_rd_ptr] <= 1'b0;
                r_bank[r_rd_ptr]     <= B_EMPTY;
                r_rd_ptr             <= r_rd_ptr + 1'b1;
                r_frames             <= r_frames + 1'b1;
            end
        end
    end

    always_comb begin
        w_all_empty = 1'b1;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (r_bank[i] != B_EMPTY) w_all_empty = 1'b0;
        end
    end

    // A go pulse marks a tracker out of E_IDLE before its ownership flag is set.
    assign w_any_active = slave_go || fft_go || master_go ||
                          (|r_filling) || (|r_computing) || (|r_draining);

    assign wr_bank     = r_wr_ptr;
    assign fft_bank    = r_fft_ptr;
    assign rd_bank     = r_rd_ptr;
    assign frames_done = r_frames;
    assign seq_idle    = w_all_empty && !w_any_active;

endmodule
